// File: rtl/halt_pkg.sv
// Shared types and Halt codes for the halt controller and its clients.
package halt_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    WAIT_IN = 2'b01,
    HALTED  = 2'b10,
    RELEASE = 2'b11
  } state_t;

  localparam logic [1:0] HALT_RUN = 2'b00;
  localparam logic [1:0] HALT_REL = 2'b01;
  localparam logic [1:0] HALT_IN  = 2'b10;
  localparam logic [1:0] HALT_END = 2'b11;

  // Halt code presented to the clock divider for a given controller state.
  function automatic logic [1:0] halt_code(input state_t s);
    logic [1:0] code;
    code = HALT_RUN;
    case (s)
      RUN:     code = HALT_RUN;
      WAIT_IN: code = HALT_IN;
      HALTED:  code = HALT_END;
      RELEASE: code = HALT_REL;
      default: code = HALT_RUN;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronises a raw push-button and reports a debounced level plus a
// one-clk strobe on each stable 0->1 transition.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 2500,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CW-1:0]          cnt_q;

  assign synced = sync_q[SYNC_STAGES-1];

  // Synchroniser chain for the asynchronous button input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Stability counter: restarts on any agreement, commits a new level after
  // DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (synced == level) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        level <= synced;
        press <= synced;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/halt_controller.sv
// Produces the Halt code for the CPU clock divider: freezes on IN/HLT decode,
// releases on a debounced button press (IN) or a context switch (HLT).
module halt_controller
  import halt_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2500,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_clk,
  input  logic       in_instr,
  input  logic       hlt_instr,
  input  logic       ctx,
  input  logic       btn_confirm,
  output logic [1:0] Halt,
  output logic       input_latch,
  output logic       frozen
);

  logic   cpu_clk_p0;
  logic   cpu_clk_p1;
  logic   cpu_rise;
  logic   cpu_fall;
  logic   btn_level;
  logic   btn_press;
  logic   press_ok;
  state_t state_q;
  state_t state_d;
  logic   seen_fall_q;
  logic   seen_fall_d;
  logic   latch_d;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_debouncer (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_confirm),
    .level (btn_level),
    .press (btn_press)
  );

  // The strobe and the level are committed together, so a real press always
  // arrives with the level already high.
  assign press_ok = btn_press & btn_level;

  // Stage p0/p1: cpu_clk sampled into the clk domain, then delayed once for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_clk_p0 <= 1'b0;
      cpu_clk_p1 <= 1'b0;
    end else begin
      cpu_clk_p0 <= cpu_clk;
      cpu_clk_p1 <= cpu_clk_p0;
    end
  end

  assign cpu_rise = cpu_clk_p0 & ~cpu_clk_p1;
  assign cpu_fall = ~cpu_clk_p0 & cpu_clk_p1;

  // Next-state logic; decode is only looked at on a CPU rising edge in RUN, so
  // the release edge itself never re-samples the still-visible old instruction.
  always_comb begin
    state_d     = state_q;
    seen_fall_d = seen_fall_q;
    latch_d     = 1'b0;
    case (state_q)
      RUN: begin
        if (cpu_rise) begin
          if (hlt_instr) begin
            state_d = HALTED;
          end else if (in_instr) begin
            state_d = WAIT_IN;
          end
        end
      end
      WAIT_IN: begin
        if (press_ok) begin
          latch_d     = 1'b1;
          state_d     = RELEASE;
          seen_fall_d = 1'b0;
        end
      end
      HALTED: begin
        if (ctx) begin
          state_d     = RELEASE;
          seen_fall_d = 1'b0;
        end
      end
      RELEASE: begin
        if (!seen_fall_q) begin
          if (cpu_fall) begin
            seen_fall_d = 1'b1;
          end
        end else if (cpu_rise) begin
          state_d     = RUN;
          seen_fall_d = 1'b0;
        end
      end
      default: begin
        state_d     = RUN;
        seen_fall_d = 1'b0;
      end
    endcase
  end

  // State and output registers; Halt is registered so it never glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      seen_fall_q <= 1'b0;
      Halt        <= HALT_RUN;
      input_latch <= 1'b0;
    end else begin
      state_q     <= state_d;
      seen_fall_q <= seen_fall_d;
      Halt        <= halt_code(state_d);
      input_latch <= latch_d;
    end
  end

  // The divider only stops while cpu_clk is high, so the clock is truly frozen
  // only once a freeze code is up and the CPU clock has reached its high phase.
  assign frozen = Halt[1] & cpu_clk;

endmodule

// File: tb/tb_halt_controller.sv
// Directed bench for halt_controller: a cycle table in manual cpu_clk mode,
// then hand sequences against a divider model that honours Halt.
module tb_halt_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_clk;
  logic       in_instr;
  logic       hlt_instr;
  logic       ctx;
  logic       btn_confirm;
  logic [1:0] Halt;
  logic       input_latch;
  logic       frozen;

  logic man;
  logic man_clk;
  logic div_q = 1'b0;
  int   dcnt = 0;
  int   latch_total = 0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       rst;
    logic       cpu;
    logic       in_i;
    logic       hlt;
    logic       cx;
    logic       btn;
    logic [1:0] halt;
    logic       latch;
    logic       frz;
  } vec_t;

  vec_t vq[$];

  halt_controller #(
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_clk     (cpu_clk),
    .in_instr    (in_instr),
    .hlt_instr   (hlt_instr),
    .ctx         (ctx),
    .btn_confirm (btn_confirm),
    .Halt        (Halt),
    .input_latch (input_latch),
    .frozen      (frozen)
  );

  always #5 clk = ~clk;

  // Divider model: toggles every 6 clk, holds while high and Halt[1] is set.
  always @(posedge clk) begin
    if (man) begin
      div_q <= man_clk;
      dcnt  <= 0;
    end else if (div_q && Halt[1]) begin
      dcnt <= 0;
    end else if (dcnt == 5) begin
      div_q <= ~div_q;
      dcnt  <= 0;
    end else begin
      dcnt <= dcnt + 1;
    end
  end

  assign cpu_clk = man ? man_clk : div_q;

  // Count clk cycles with input_latch high.
  always @(posedge clk) begin
    if (input_latch) latch_total <= latch_total + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_halt(input logic [1:0] code, input int max, input string name);
    int n;
    n = 0;
    while (Halt !== code && n < max) begin
      tick();
      n++;
    end
    check(name, {30'd0, Halt}, {30'd0, code});
  endtask

  task automatic press_btn();
    btn_confirm = 1'b1;
    ticks(6);
    btn_confirm = 1'b0;
  endtask

  task automatic cpu_stays_high(input int n, input string name);
    logic stayed;
    stayed = 1'b1;
    repeat (n) begin
      tick();
      if (cpu_clk !== 1'b1) stayed = 1'b0;
    end
    check(name, {31'd0, stayed}, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1);
  end

  initial begin
    int snap;
    reset = 1'b1; man = 1'b1; man_clk = 1'b0;
    in_instr = 1'b0; hlt_instr = 1'b0; ctx = 1'b0; btn_confirm = 1'b0;

    //            rst cpu in hlt ctx btn  halt  lat frz
    vq.push_back('{1, 0, 0, 0, 0, 0, 2'b00, 0, 0});
    vq.push_back('{0, 0, 0, 0, 0, 0, 2'b00, 0, 0});
    vq.push_back('{0, 1, 1, 0, 0, 0, 2'b00, 0, 0});
    vq.push_back('{0, 1, 1, 0, 0, 0, 2'b10, 0, 1});
    vq.push_back('{0, 1, 0, 0, 0, 0, 2'b10, 0, 1});
    vq.push_back('{0, 0, 0, 0, 0, 0, 2'b10, 0, 0});
    vq.push_back('{0, 0, 0, 0, 1, 0, 2'b10, 0, 0});
    vq.push_back('{1, 0, 0, 0, 0, 0, 2'b00, 0, 0});
    vq.push_back('{0, 0, 0, 0, 0, 0, 2'b00, 0, 0});
    vq.push_back('{0, 1, 1, 1, 0, 0, 2'b00, 0, 0});
    vq.push_back('{0, 1, 1, 1, 0, 0, 2'b11, 0, 1});
    for (int i = 0; i < 7; i++) vq.push_back('{0, 1, 0, 0, 0, 1, 2'b11, 0, 1});
    vq.push_back('{0, 1, 0, 0, 1, 0, 2'b01, 0, 0});
    vq.push_back('{0, 1, 0, 0, 0, 0, 2'b01, 0, 0});
    vq.push_back('{0, 0, 0, 0, 0, 0, 2'b01, 0, 0});
    vq.push_back('{0, 0, 0, 0, 0, 0, 2'b01, 0, 0});
    vq.push_back('{0, 1, 1, 0, 0, 0, 2'b01, 0, 0});
    vq.push_back('{0, 1, 1, 0, 0, 0, 2'b00, 0, 0});
    vq.push_back('{0, 1, 1, 0, 0, 0, 2'b00, 0, 0});
    vq.push_back('{0, 0, 1, 0, 0, 0, 2'b00, 0, 0});
    vq.push_back('{0, 1, 1, 0, 0, 0, 2'b00, 0, 0});
    vq.push_back('{0, 1, 1, 0, 0, 0, 2'b10, 0, 1});

    #2;
    for (int i = 0; i < vq.size(); i++) begin
      reset       = vq[i].rst;
      man_clk     = vq[i].cpu;
      in_instr    = vq[i].in_i;
      hlt_instr   = vq[i].hlt;
      ctx         = vq[i].cx;
      btn_confirm = vq[i].btn;
      tick();
      tests++;
      if (Halt !== vq[i].halt || input_latch !== vq[i].latch || frozen !== vq[i].frz) begin
        fails++;
        $display("FAIL vec%0d: Halt=%b latch=%b frozen=%b expected Halt=%b latch=%b frozen=%b",
                 i, Halt, input_latch, frozen, vq[i].halt, vq[i].latch, vq[i].frz);
      end
    end

    // Async reset while in WAIT_IN takes effect mid-cycle.
    in_instr = 1'b0;
    @(negedge clk);
    reset   = 1'b1;
    man_clk = 1'b0;
    #1;
    check("async_reset_halt", {30'd0, Halt}, 32'd0);
    check("async_reset_latch", {31'd0, input_latch}, 32'd0);
    tick();
    man = 1'b0;
    tick();
    reset = 1'b0;
    ticks(3);
    check("run_after_reset", {30'd0, Halt}, 32'd0);

    // Input wait, freeze with cpu_clk high, single latch on press, release.
    in_instr = 1'b1;
    wait_halt(2'b10, 40, "t2_enter_wait");
    in_instr = 1'b0;
    check("t2_frozen", {31'd0, frozen}, 32'd1);
    cpu_stays_high(14, "t2_cpu_held");
    snap = latch_total;
    press_btn();
    wait_halt(2'b01, 20, "t2_release_pending");
    wait_halt(2'b00, 40, "t2_back_to_run");
    check("t2_one_latch", latch_total - snap, 32'd1);

    // Glitch rejected; button held across entry does not release.
    in_instr = 1'b1;
    wait_halt(2'b10, 40, "t3_enter_wait");
    in_instr = 1'b0;
    snap = latch_total;
    btn_confirm = 1'b1;
    ticks(3);
    btn_confirm = 1'b0;
    ticks(12);
    check("t3_glitch_halt", {30'd0, Halt}, 32'd2);
    check("t3_glitch_latch", latch_total - snap, 32'd0);
    press_btn();
    wait_halt(2'b00, 60, "t3_exit");
    btn_confirm = 1'b1;
    ticks(12);
    in_instr = 1'b1;
    wait_halt(2'b10, 40, "t3_enter_held");
    in_instr = 1'b0;
    snap = latch_total;
    ticks(15);
    check("t3_held_halt", {30'd0, Halt}, 32'd2);
    check("t3_held_latch", latch_total - snap, 32'd0);
    btn_confirm = 1'b0;
    ticks(10);
    check("t3_after_unpress", {30'd0, Halt}, 32'd2);
    press_btn();
    wait_halt(2'b01, 20, "t3_fresh_press");
    wait_halt(2'b00, 40, "t3_run");
    check("t3_fresh_latch", latch_total - snap, 32'd1);

    // HLT wins over IN; button ignored; ctx releases.
    in_instr  = 1'b1;
    hlt_instr = 1'b1;
    wait_halt(2'b11, 40, "t4_enter_halt");
    in_instr  = 1'b0;
    hlt_instr = 1'b0;
    check("t4_frozen", {31'd0, frozen}, 32'd1);
    snap = latch_total;
    press_btn();
    ticks(12);
    check("t4_btn_ignored", {30'd0, Halt}, 32'd3);
    ctx = 1'b1;
    tick();
    ctx = 1'b0;
    check("t4_ctx_release", {30'd0, Halt}, 32'd1);
    wait_halt(2'b00, 40, "t4_run");
    check("t4_no_latch", latch_total - snap, 32'd0);

    // Freeze requested while cpu_clk is low: low phase completes, then hold high.
    man     = 1'b1;
    man_clk = 1'b0;
    ticks(2);
    man_clk  = 1'b1;
    in_instr = 1'b1;
    tick();
    man_clk = 1'b0;
    tick();
    man      = 1'b0;
    in_instr = 1'b0;
    check("t5_halt_low", {30'd0, Halt}, 32'd2);
    check("t5_not_frozen_low", {31'd0, frozen}, 32'd0);
    begin
      int n;
      n = 0;
      while (cpu_clk !== 1'b1 && n < 12) begin
        tick();
        n++;
      end
    end
    check("t5_frozen_after_rise", {31'd0, frozen}, 32'd1);
    cpu_stays_high(15, "t5_no_more_toggles");

    // Release with in_instr still high: first rise ignored, second re-freezes.
    press_btn();
    wait_halt(2'b01, 20, "t6_release_pending");
    in_instr = 1'b1;
    wait_halt(2'b00, 40, "t6_run");
    ticks(8);
    check("t6_no_refreeze", {30'd0, Halt}, 32'd0);
    wait_halt(2'b10, 20, "t6_refreeze");
    in_instr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
